jedro_1_lsu: RTL and testbench

Load-store unit for the jedro_1 core, sitting directly downstream of the decoder and driving the core's data interface. It accepts one memory operation per command (load or store, byte/half/word), computes byte enables and lane-aligned write data, runs the req/gnt/rvalid handshake, and returns sign/zero-extended load data to the register file writeback port. Misaligned accesses and bus errors are flagged rather than issued or written back.

---
 rtl/jedro_1_lsu.sv | 172 +++++++++++++++++
 tb/tb_jedro_1_lsu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_lsu.sv
// jedro_1 load-store unit: one load/store per command, req/gnt/rvalid bus
// handshake, byte-lane formatting, and sign/zero-extended load writeback.
//
// Ports:
//   clk_i, rst_i              clock, async active-high reset
//   lsu_new_ctrl_i            command strobe, taken only while not busy
//   lsu_ctrl_i                [3] store, [2] unsigned load, [1:0] size
//   lsu_regdest_i             load destination register
//   lsu_addr_i, lsu_wdata_i   effective byte address, right-aligned store data
//   data_*                    core data bus (request fields held while req)
//   busy_o                    command in flight
//   rf_wb_o/_addr_o/_data_o   load writeback (1-cycle pulse)
//   done_o                    store completion pulse
//   misaligned_o, bus_err_o   rejection / bus error pulses
module jedro_1_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lsu_new_ctrl_i,
    input  logic [3:0]            lsu_ctrl_i,
    input  logic [4:0]            lsu_regdest_i,
    input  logic [DATA_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_addr_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
    input  logic                  data_err_i,
    output logic                  busy_o,
    output logic                  rf_wb_o,
    output logic [4:0]            rf_wb_addr_o,
    output logic [DATA_WIDTH-1:0] rf_wb_data_o,
    output logic                  done_o,
    output logic                  misaligned_o,
    output logic                  bus_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic       store_q;
    logic       unsigned_q;
    logic [1:0] size_q;
    logic [1:0] off_q;
    logic [4:0] regdest_q;
    logic       mis_q;
    logic       err_q;

    logic [1:0]            off;
    logic [1:0]            size;
    logic                  illegal;
    logic                  accept;
    logic [3:0]            be_fmt;
    logic [DATA_WIDTH-1:0] wd_fmt;
    logic [DATA_WIDTH-1:0] rd_sh;
    logic [DATA_WIDTH-1:0] ld_fmt;

    assign off    = lsu_addr_i[1:0];
    assign size   = lsu_ctrl_i[1:0];
    assign accept = (state == IDLE) && lsu_new_ctrl_i;

    assign illegal = (size == 2'b11)
                   || (size == 2'b01 && off[0])
                   || (size == 2'b10 && off != 2'b00);

    // Store formatting: move the right-aligned data onto its byte lanes.
    always_comb begin
        be_fmt = 4'b1111;
        wd_fmt = lsu_wdata_i;
        unique case (size)
            2'b00: begin
                be_fmt = 4'b0001 << off;
                wd_fmt = {24'b0, lsu_wdata_i[7:0]} << {off, 3'b000};
            end
            2'b01: begin
                be_fmt = 4'b0011 << off;
                wd_fmt = {16'b0, lsu_wdata_i[15:0]} << {off, 3'b000};
            end
            default: begin
                be_fmt = 4'b1111;
                wd_fmt = lsu_wdata_i;
            end
        endcase
    end

    // Load formatting: shift the addressed lane down, then extend.
    assign rd_sh = data_rdata_i >> {off_q, 3'b000};

    always_comb begin
        ld_fmt = rd_sh;
        unique case (size_q)
            2'b00: ld_fmt = unsigned_q ? {24'b0, rd_sh[7:0]}
                                       : {{24{rd_sh[7]}}, rd_sh[7:0]};
            2'b01: ld_fmt = unsigned_q ? {16'b0, rd_sh[15:0]}
                                       : {{16{rd_sh[15]}}, rd_sh[15:0]};
            default: ld_fmt = rd_sh;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (lsu_new_ctrl_i) state_nxt = illegal ? RESP : REQ;
            REQ:  if (data_gnt_i)     state_nxt = WAIT;
            WAIT: if (data_rvalid_i)  state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            store_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            regdest_q    <= 5'd0;
            mis_q        <= 1'b0;
            err_q        <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
            rf_wb_data_o <= '0;
        end else begin
            if (accept) begin
                store_q      <= lsu_ctrl_i[3];
                unsigned_q   <= lsu_ctrl_i[2];
                size_q       <= size;
                off_q        <= off;
                regdest_q    <= lsu_regdest_i;
                mis_q        <= illegal;
                err_q        <= 1'b0;
                data_we_o    <= lsu_ctrl_i[3];
                data_be_o    <= be_fmt;
                data_addr_o  <= {lsu_addr_i[DATA_WIDTH-1:2], 2'b00};
                data_wdata_o <= wd_fmt;
            end
            if (state == WAIT && data_rvalid_i) begin
                err_q        <= data_err_i;
                rf_wb_data_o <= ld_fmt;
            end
        end
    end

    assign data_req_o   = (state == REQ);
    assign busy_o       = (state != IDLE);
    assign rf_wb_addr_o = regdest_q;

    // Exactly one result pulse in RESP, prioritised mis > err > wb/done.
    assign misaligned_o = (state == RESP) && mis_q;
    assign bus_err_o    = (state == RESP) && !mis_q && err_q;
    assign rf_wb_o      = (state == RESP) && !mis_q && !err_q && !store_q;
    assign done_o       = (state == RESP) && !mis_q && !err_q && store_q;

endmodule

// File: tb/tb_jedro_1_lsu.sv
// Self-checking bench for jedro_1_lsu: table of single-command vectors
// plus hand-written sequences for stalls, stray inputs and reset.
module tb_jedro_1_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_ctrl;
    logic [3:0]  ctrl;
    logic [4:0]  regdest;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        we;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    logic        wb;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        done;
    logic        mis;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jedro_1_lsu #(.DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .lsu_new_ctrl_i(new_ctrl), .lsu_ctrl_i(ctrl),
        .lsu_regdest_i(regdest), .lsu_addr_i(addr), .lsu_wdata_i(wdata),
        .data_req_o(req), .data_gnt_i(gnt), .data_rvalid_i(rvalid),
        .data_we_o(we), .data_be_o(be), .data_addr_o(baddr),
        .data_wdata_o(bwdata), .data_rdata_i(rdata), .data_err_i(err),
        .busy_o(busy), .rf_wb_o(wb), .rf_wb_addr_o(wb_addr),
        .rf_wb_data_o(wb_data), .done_o(done),
        .misaligned_o(mis), .bus_err_o(bus_err)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] wbdata;
        logic        mis;
    } vec_t;

    vec_t vec [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v        = vec[i];
        new_ctrl = 1'b1;
        ctrl     = v.ctrl;
        addr     = v.addr;
        wdata    = v.wdata;
        regdest  = 5'(i + 1);
        tick();
        new_ctrl = 1'b0;
        if (v.mis) begin
            chk($sformatf("v%0d mis", i), 32'(mis), 32'd1);
            chk($sformatf("v%0d mis req", i), 32'(req), 32'd0);
            chk($sformatf("v%0d mis wb", i), 32'(wb), 32'd0);
            tick();
            chk($sformatf("v%0d mis once", i), 32'(mis), 32'd0);
            chk($sformatf("v%0d mis busy", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d mis req2", i), 32'(req), 32'd0);
            return;
        end
        chk($sformatf("v%0d req", i), 32'(req), 32'd1);
        chk($sformatf("v%0d addr", i), baddr, v.addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d be", i), 32'(be), 32'(v.be));
        chk($sformatf("v%0d we", i), 32'(we), 32'(v.ctrl[3]));
        if (v.ctrl[3])
            chk($sformatf("v%0d wdata", i), bwdata, v.bwdata);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk($sformatf("v%0d req drop", i), 32'(req), 32'd0);
        chk($sformatf("v%0d busy", i), 32'(busy), 32'd1);
        rvalid = 1'b1;
        rdata  = v.rdata;
        err    = v.err;
        tick();
        rvalid = 1'b0;
        err    = 1'b0;
        chk($sformatf("v%0d wb", i), 32'(wb),
            32'(!v.err && !v.ctrl[3]));
        chk($sformatf("v%0d done", i), 32'(done),
            32'(!v.err && v.ctrl[3]));
        chk($sformatf("v%0d bus_err", i), 32'(bus_err), 32'(v.err));
        if (!v.err && !v.ctrl[3]) begin
            chk($sformatf("v%0d wb_data", i), wb_data, v.wbdata);
            chk($sformatf("v%0d wb_addr", i), 32'(wb_addr), 32'(i + 1));
        end
        tick();
        chk($sformatf("v%0d idle", i), 32'(busy), 32'd0);
        chk($sformatf("v%0d pulse", i), 32'({wb, done, bus_err}), 32'd0);
    endtask

    initial begin
        vec[0]  = '{4'b0010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0,
                    4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vec[1]  = '{4'b0000, 32'h103, 32'h0, 32'h8012_3456, 1'b0,
                    4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0};
        vec[2]  = '{4'b0100, 32'h103, 32'h0, 32'h8012_3456, 1'b0,
                    4'b1000, 32'h0, 32'h0000_0080, 1'b0};
        vec[3]  = '{4'b0001, 32'h102, 32'h0, 32'h9ABC_1234, 1'b0,
                    4'b1100, 32'h0, 32'hFFFF_9ABC, 1'b0};
        vec[4]  = '{4'b0101, 32'h200, 32'h0, 32'h1234_F00D, 1'b0,
                    4'b0011, 32'h0, 32'h0000_F00D, 1'b0};
        vec[5]  = '{4'b1000, 32'h301, 32'h0000_00A5, 32'h0, 1'b0,
                    4'b0010, 32'h0000_A500, 32'h0, 1'b0};
        vec[6]  = '{4'b1010, 32'h400, 32'hCAFE_F00D, 32'h0, 1'b0,
                    4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0};
        vec[7]  = '{4'b0010, 32'h101, 32'h0, 32'h0, 1'b0,
                    4'b0000, 32'h0, 32'h0, 1'b1};
        vec[8]  = '{4'b0011, 32'h100, 32'h0, 32'h0, 1'b0,
                    4'b0000, 32'h0, 32'h0, 1'b1};
        vec[9]  = '{4'b0010, 32'h104, 32'h0, 32'h1111_2222, 1'b1,
                    4'b1111, 32'h0, 32'h0, 1'b0};
        vec[10] = '{4'b1001, 32'h203, 32'h0, 32'h0, 1'b0,
                    4'b0000, 32'h0, 32'h0, 1'b1};

        rst = 1'b1; new_ctrl = 1'b0; ctrl = 4'h0; regdest = 5'd0;
        addr = 32'h0; wdata = 32'h0; gnt = 1'b0; rvalid = 1'b0;
        rdata = 32'h0; err = 1'b0;
        tick();
        tick();
        chk("rst req", 32'(req), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst be", 32'(be), 32'd0);
        chk("rst addr", baddr, 32'h0);
        chk("rst wdata", bwdata, 32'h0);
        chk("rst wb_data", wb_data, 32'h0);
        chk("rst pulses", 32'({wb, done, mis, bus_err, we}), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) run_vec(i);

        // Half store with a 3-cycle gnt stall and a dropped strobe in WAIT.
        new_ctrl = 1'b1; ctrl = 4'b1001; addr = 32'h202;
        wdata = 32'h1234_ABCD; regdest = 5'd7;
        tick();
        new_ctrl = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d req", k), 32'(req), 32'd1);
            chk($sformatf("stall%0d be", k), 32'(be), 32'b1100);
            chk($sformatf("stall%0d wdata", k), bwdata, 32'hABCD_0000);
            chk($sformatf("stall%0d addr", k), baddr, 32'h200);
            tick();
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        new_ctrl = 1'b1; ctrl = 4'b0010; addr = 32'h500;
        tick();
        new_ctrl = 1'b0;
        chk("busy strobe addr", baddr, 32'h200);
        chk("busy strobe req", 32'(req), 32'd0);
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        chk("stall done", 32'(done), 32'd1);
        tick();
        chk("stall done once", 32'(done), 32'd0);
        chk("stall idle", 32'(busy), 32'd0);
        tick();
        chk("dropped cmd req", 32'(req), 32'd0);

        // Stray rvalid while idle.
        rvalid = 1'b1; rdata = 32'h5555_5555;
        tick();
        rvalid = 1'b0;
        chk("stray busy", 32'(busy), 32'd0);
        chk("stray pulses", 32'({wb, done, mis, bus_err, req}), 32'd0);

        // Reset while waiting for rvalid.
        new_ctrl = 1'b1; ctrl = 4'b0010; addr = 32'h600; regdest = 5'd3;
        tick();
        new_ctrl = 1'b0;
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("pre-rst busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst addr", baddr, 32'h0);
        chk("async rst be", 32'(be), 32'd0);
        chk("async rst outs", 32'({req, we, wb, done, mis, bus_err}), 32'd0);
        tick();
        rst = 1'b0;
        rvalid = 1'b1; rdata = 32'h7777_7777;
        tick();
        rvalid = 1'b0;
        chk("post-rst stray", 32'({wb, busy}), 32'd0);
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
